// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the instruction word width, the store opcode encoding used by
// decode, and the fetch FSM state enumeration.
package fetch_pkg;

  localparam int INSTR_WIDTH = 20;

  localparam logic [3:0] OPCODE_STORE = 4'b1100;

  // EMPTY: no read in flight; RUN: read in flight, skid empty;
  // HOLD: stalled with the in-flight word parked in the skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry skid register for the fetch stage.
// Parks the word returned by instruction memory (and its address) when
// decode stalls while a read is already in flight, so the word is not lost.
// Ports:
//   clock, reset     - clock and asynchronous active-high reset
//   load             - capture d_data/d_pc and mark the entry valid
//   clear            - empty the entry (wins over load)
//   d_data, d_pc     - word and address to capture
//   q_data, q_pc     - parked word and address
//   q_valid          - entry holds a parked word
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] d_data,
  input  logic [PC_WIDTH-1:0]    d_pc,
  output logic [INSTR_WIDTH-1:0] q_data,
  output logic [PC_WIDTH-1:0]    q_pc,
  output logic                   q_valid
);

  // Clear takes priority so a redirect or reset always discards a parked word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_data  <= '0;
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (clear) begin
      q_data  <= '0;
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_pc    <= d_pc;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with a one-cycle-latency instruction memory.
// Issues sequential reads, redirects on taken branches, and absorbs decode
// stalls with a one-entry skid so no fetched word is lost or duplicated.
// Ports:
//   clock, reset            - clock and asynchronous active-high reset
//   stall                   - decode hold request
//   branch_taken            - redirect request from execute
//   branch_target           - redirect address
//   imem_addr               - instruction memory read address (= fetch_pc)
//   imem_data               - instruction memory read data, one cycle later
//   instruction, pc_out     - IF/ID register word and its address
//   instr_valid             - IF/ID register holds a real instruction
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                   PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   instr_valid
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t state;

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    req_pc;
  logic                   req_valid;

  logic                   skid_load;
  logic                   skid_clear;
  logic [INSTR_WIDTH-1:0] skid_data;
  logic [PC_WIDTH-1:0]    skid_pc;
  logic                   skid_valid;

  assign imem_addr = fetch_pc;

  // The skid captures the in-flight word when a stall first hits RUN, and is
  // emptied either by a redirect or when HOLD drains it into IF/ID.
  always_comb begin
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (branch_taken) begin
      skid_clear = 1'b1;
    end else if (state == RUN && stall) begin
      skid_load = 1'b1;
    end else if (state == HOLD && !stall) begin
      skid_clear = 1'b1;
    end
  end

  fetch_skid_buffer #(
    .PC_WIDTH (PC_WIDTH)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_data  (imem_data),
    .d_pc    (req_pc),
    .q_data  (skid_data),
    .q_pc    (skid_pc),
    .q_valid (skid_valid)
  );

  // Fetch FSM. Priority is branch, then stall, then normal flow. Issuing a
  // read records the address in req_pc because the memory answers one cycle
  // later, by which time fetch_pc has already advanced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      req_valid   <= 1'b0;
      instruction <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      state       <= EMPTY;
      fetch_pc    <= branch_target;
      req_valid   <= 1'b0;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (!stall) begin
            req_pc      <= fetch_pc;
            req_valid   <= 1'b1;
            fetch_pc    <= fetch_pc + PC_ONE;
            instruction <= '0;
            instr_valid <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            instruction <= imem_data;
            pc_out      <= req_pc;
            instr_valid <= req_valid;
            req_pc      <= fetch_pc;
            req_valid   <= 1'b1;
            fetch_pc    <= fetch_pc + PC_ONE;
          end else begin
            req_valid <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instruction <= skid_data;
            pc_out      <= skid_pc;
            instr_valid <= skid_valid;
            req_pc      <= fetch_pc;
            req_valid   <= 1'b1;
            fetch_pc    <= fetch_pc + PC_ONE;
            state       <= RUN;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// Directed vector table, hand-written corner sequences, and a randomized
// phase checked against a delivery-level reference model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data;
  logic [19:0] instruction;
  logic [7:0]  pc_out;
  logic        instr_valid;

  logic        fe_reset;
  logic        fe_stall  = 1'b0;
  logic        fe_branch = 1'b0;
  logic [7:0]  fe_target = 8'h00;
  logic [7:0]  fe_imem_addr;
  logic [19:0] fe_imem_data;
  logic [19:0] fe_instruction;
  logic [7:0]  fe_pc_out;
  logic        fe_instr_valid;

  logic [19:0] mem [256];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        s;
    logic        b;
    logic [7:0]  t;
    logic        ev;
    logic [7:0]  epc;
    logic [19:0] einstr;
  } vec_t;

  vec_t vecs [14];

  always #5 clock = ~clock;

  // Registered instruction memory shared by both instances.
  always @(posedge clock) begin
    imem_data    <= mem[imem_addr];
    fe_imem_data <= mem[fe_imem_addr];
  end

  instruction_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  instruction_fetch #(.PC_WIDTH(8), .RESET_PC(8'hFE)) dut_fe (
    .clock         (clock),
    .reset         (fe_reset),
    .stall         (fe_stall),
    .branch_taken  (fe_branch),
    .branch_target (fe_target),
    .imem_addr     (fe_imem_addr),
    .imem_data     (fe_imem_data),
    .instruction   (fe_instruction),
    .pc_out        (fe_pc_out),
    .instr_valid   (fe_instr_valid)
  );

  // Drive one cycle of inputs, let the edge happen, and settle 1 time unit.
  task automatic applyStimulus(input logic s, input logic b, input logic [7:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic av, input logic [7:0] apc, input logic [19:0] ainstr,
                             input logic ev, input logic [7:0] epc, input logic [19:0] einstr);
    total++;
    if (av !== ev) begin
      bad++;
      $display("[TB] FAIL %s instr_valid: got %b expected %b", name, av, ev);
    end
    total++;
    if (apc !== epc) begin
      bad++;
      $display("[TB] FAIL %s pc_out: got %h expected %h", name, apc, epc);
    end
    total++;
    if (ainstr !== einstr) begin
      bad++;
      $display("[TB] FAIL %s instruction: got %h expected %h", name, ainstr, einstr);
    end
  endtask

  task automatic checkAddr(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s imem_addr: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0]  m_next;
    int          m_warm;
    logic        m_valid;
    logic [7:0]  m_pc;
    logic [19:0] m_instr;
    logic        rs, rb;
    logic [7:0]  rt;

    // Directed table: reset free run, 3-cycle stall at pc 2, branch to 40 at pc 5.
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h00000};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 20'h10000};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 20'h10001};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 20'h10002};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 20'h10002};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 20'h10002};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 20'h10002};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 20'h10003};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 20'h10004};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 20'h10005};
    vecs[10] = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h05, 20'h00000};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 20'h00000};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 20'h10040};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 20'h10041};

    for (int i = 0; i < 256; i++) mem[i] = 20'h10000 + 20'(i);

    stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    reset = 1'b1; fe_reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", instr_valid, pc_out, instruction, 1'b0, 8'h00, 20'h0);
    checkAddr("reset", imem_addr, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].s, vecs[i].b, vecs[i].t);
      checkOutput($sformatf("vec%0d", i), instr_valid, pc_out, instruction,
                  vecs[i].ev, vecs[i].epc, vecs[i].einstr);
    end

    // Branch and stall together while the skid is full: branch must win.
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("hold_enter", instr_valid, pc_out, instruction, 1'b1, 8'h41, 20'h10041);
    applyStimulus(1'b1, 1'b1, 8'h80);
    checkOutput("hold_branch", instr_valid, pc_out, instruction, 1'b0, 8'h41, 20'h0);
    checkAddr("hold_branch", imem_addr, 8'h80);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("hold_bubble", instr_valid, pc_out, instruction, 1'b0, 8'h41, 20'h0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("hold_target", instr_valid, pc_out, instruction, 1'b1, 8'h80, 20'h10080);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("hold_next", instr_valid, pc_out, instruction, 1'b1, 8'h81, 20'h10081);

    // Asynchronous reset in the middle of a HOLD cycle.
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("arst_hold", instr_valid, pc_out, instruction, 1'b1, 8'h81, 20'h10081);
    #3 reset = 1'b1;
    #1;
    checkOutput("arst_now", instr_valid, pc_out, instruction, 1'b0, 8'h00, 20'h0);
    checkAddr("arst_now", imem_addr, 8'h00);
    #1 reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("arst_e1", instr_valid, pc_out, instruction, 1'b0, 8'h00, 20'h0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("arst_e2", instr_valid, pc_out, instruction, 1'b1, 8'h00, 20'h10000);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("arst_e3", instr_valid, pc_out, instruction, 1'b1, 8'h01, 20'h10001);

    // Non-zero reset PC wrapping through the top of the address space.
    fe_reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("fe_e1", fe_instr_valid, fe_pc_out, fe_instruction, 1'b0, 8'h00, 20'h0);
    @(posedge clock); #1;
    checkOutput("fe_e2", fe_instr_valid, fe_pc_out, fe_instruction, 1'b1, 8'hFE, 20'h100FE);
    @(posedge clock); #1;
    checkOutput("fe_e3", fe_instr_valid, fe_pc_out, fe_instruction, 1'b1, 8'hFF, 20'h100FF);
    @(posedge clock); #1;
    checkOutput("fe_e4", fe_instr_valid, fe_pc_out, fe_instruction, 1'b1, 8'h00, 20'h10000);
    @(posedge clock); #1;
    checkOutput("fe_e5", fe_instr_valid, fe_pc_out, fe_instruction, 1'b1, 8'h01, 20'h10001);

    // Randomized phase. The model only tracks which address is delivered
    // next and how many unstalled cycles of refill remain before delivery.
    reset = 1'b1;
    stall = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 20'($urandom);
    #3 reset = 1'b0;
    m_next = 8'h00; m_warm = 1; m_valid = 1'b0; m_pc = 8'h00; m_instr = 20'h0;
    for (int c = 0; c < 400; c++) begin
      rb = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 9) < 3);
      rt = 8'($urandom);
      applyStimulus(rs, rb, rt);
      if (rb) begin
        m_valid = 1'b0; m_instr = 20'h0; m_next = rt; m_warm = 1;
      end else if (!rs) begin
        if (m_warm > 0) begin
          m_warm--; m_valid = 1'b0; m_instr = 20'h0;
        end else begin
          m_valid = 1'b1; m_pc = m_next; m_instr = mem[m_next]; m_next = m_next + 8'd1;
        end
      end
      checkOutput($sformatf("rand%0d", c), instr_valid, pc_out, instruction, m_valid, m_pc, m_instr);
      checkAddr($sformatf("rand%0d", c), imem_addr, (m_warm == 0) ? m_next + 8'd1 : m_next);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
